spy_bus_arbiter: RTL and testbench



---
 rtl/spy_bus_arbiter_if.sv | 51 +++++
 rtl/spy_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_spy_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spy_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// spy_bus_arbiter_if
//   Groups the two requester handshakes and the shared spy bus into a
//   single bundle.
//
//   Requester side : req0/1, we0/1, addr0/1[4:0], wdata0/1[15:0], lock0/1
//                    -> ack0/1, rdata0/1[15:0]
//   Status         : grant[1:0] (one-hot owner), busy
//   Spy bus        : eadr[4:0], spy_out[15:0], dbread, dbwrite, spy_in[15:0]
//
//   slave  : the arbiter's view (drives acks, read data, status, bus strobes).
//   master : the environment's view (requesters plus the spy register file
//            that returns spy_in).
// ---------------------------------------------------------------------------
interface spy_bus_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [4:0]  addr0;
  logic [4:0]  addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        lock0;
  logic        lock1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic [1:0]  grant;
  logic        busy;
  logic [4:0]  eadr;
  logic [15:0] spy_out;
  logic [15:0] spy_in;
  logic        dbread;
  logic        dbwrite;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  spy_in,
    output ack0, ack1, rdata0, rdata1, grant, busy,
    output eadr, spy_out, dbread, dbwrite
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output spy_in,
    input  ack0, ack1, rdata0, rdata1, grant, busy,
    input  eadr, spy_out, dbread, dbwrite
  );
endinterface

// File: rtl/spy_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spy_bus_arbiter
//   Shares the single spy bus between requester 0 (UART spy command engine)
//   and requester 1 (HPS debug bridge). Each requester issues one read or
//   write at a time over a level req / one-cycle ack handshake. Ownership is
//   round-robin; the arbiter sequences setup, strobe and hold timing and
//   returns read data to the requester that issued the read.
//
//   Parameters : READ_CYCLES  (1..15) cycles dbread is held high
//                WRITE_CYCLES (1..15) cycles dbwrite is held high
//   Ports      : clk   - system clock
//                reset - synchronous, active-high reset
//                bus   - spy_bus_arbiter_if.slave (handshakes + spy bus)
//
//   Optional feature, macro SPY_ARB_LOCK_EN: a requester holding its lock
//   input high at the ACK of its own transaction keeps exclusive ownership
//   until it is seen with lock low while the arbiter is idle. Without the
//   macro lock0/lock1 are ignored.
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module spy_bus_arbiter #(
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  spy_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, HOLD, ACK} state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_CYCLES);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        gidx_q, gidx_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic [4:0]  eadr_q, eadr_d;
  logic [15:0] spy_out_q, spy_out_d;
  logic        dbread_q, dbread_d;
  logic        dbwrite_q, dbwrite_d;

  logic [1:0]  req_eff;
  logic        pick;

`ifdef SPY_ARB_LOCK_EN
  logic        lock_act_q, lock_act_d;
  logic        lock_own_q, lock_own_d;
`else
  // Lock inputs have no function in this build.
  logic        unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gidx_d       = gidx_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    eadr_d       = eadr_q;
    spy_out_d    = spy_out_q;
    dbread_d     = dbread_q;
    dbwrite_d    = dbwrite_q;
    req_eff      = {bus.req1, bus.req0};
    pick         = 1'b0;
`ifdef SPY_ARB_LOCK_EN
    lock_act_d   = lock_act_q;
    lock_own_d   = lock_own_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef SPY_ARB_LOCK_EN
        // While locked only the owner may be granted; the lock drops the
        // first idle cycle the owner shows lock low, and normal arbitration
        // applies in that same cycle.
        if (lock_act_q) begin
          if (lock_own_q ? bus.lock1 : bus.lock0) begin
            req_eff = req_eff & (lock_own_q ? 2'b10 : 2'b01);
          end else begin
            lock_act_d = 1'b0;
          end
        end
`endif
        if (req_eff != 2'b00) begin
          // Contention goes to whoever was not served last.
          pick    = (req_eff == 2'b11) ? ~last_grant_q : req_eff[1];
          gidx_d  = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          grant_d = pick ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        // Address and data are driven together with the first strobe
        // cycle and stay put until the next transaction.
        eadr_d = addr_q;
        if (we_q) begin
          spy_out_d = wdata_q;
          dbwrite_d = 1'b1;
          cnt_d     = WR_LOAD;
          state_d   = WRITE;
        end else begin
          dbread_d  = 1'b1;
          cnt_d     = RD_LOAD;
          state_d   = READ;
        end
      end

      READ: begin
        if (cnt_q <= 4'd1) begin
          // Edge ending the last dbread cycle: capture and acknowledge.
          dbread_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = ACK;
          ack0_d   = ~gidx_q;
          ack1_d   = gidx_q;
          if (gidx_q) rdata1_d = bus.spy_in;
          else        rdata0_d = bus.spy_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WRITE: begin
        if (cnt_q <= 4'd1) begin
          dbwrite_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        ack0_d  = ~gidx_q;
        ack1_d  = gidx_q;
        state_d = ACK;
      end

      ACK: begin
        last_grant_d = gidx_q;
        grant_d      = 2'b00;
        busy_d       = 1'b0;
        state_d      = IDLE;
`ifdef SPY_ARB_LOCK_EN
        if (gidx_q ? bus.lock1 : bus.lock0) begin
          lock_act_d = 1'b1;
          lock_own_d = gidx_q;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      gidx_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 5'd0;
      wdata_q      <= 16'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 16'd0;
      rdata1_q     <= 16'd0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      eadr_q       <= 5'd0;
      spy_out_q    <= 16'd0;
      dbread_q     <= 1'b0;
      dbwrite_q    <= 1'b0;
`ifdef SPY_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_own_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gidx_q       <= gidx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      eadr_q       <= eadr_d;
      spy_out_q    <= spy_out_d;
      dbread_q     <= dbread_d;
      dbwrite_q    <= dbwrite_d;
`ifdef SPY_ARB_LOCK_EN
      lock_act_q   <= lock_act_d;
      lock_own_q   <= lock_own_d;
`endif
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.eadr    = eadr_q;
  assign bus.spy_out = spy_out_q;
  assign bus.dbread  = dbread_q;
  assign bus.dbwrite = dbwrite_q;

endmodule

// File: tb/tb_spy_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spy_bus_arbiter
//   Directed bench for spy_bus_arbiter. A transaction-level model predicts
//   every output each cycle from the timing rules (setup cycle, strobe
//   window, ack cycle, round-robin choice); directed tests add literal
//   expectations at known cycles. Build with +define+SPY_ARB_LOCK_EN to
//   also exercise the lock feature.
// ---------------------------------------------------------------------------
module tb_spy_bus_arbiter;
  localparam int RC = 2;
  localparam int WC = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spy_bus_arbiter_if bus ();

  spy_bus_arbiter #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- model state ----------------
  int          cyc = 0;
  bit          mdl_on = 0;
  bit          t_act = 0, t_we = 0, t_own = 0, in_tx = 0;
  logic [4:0]  t_addr = '0;
  logic [15:0] t_wdata = '0, t_rd = '0;
  int          t_s = 0, t_ack = 0;
  logic [4:0]  e_eadr = '0;
  logic [15:0] e_sout = '0, e_rd0 = '0, e_rd1 = '0;
  bit          last = 1;
  bit          lk_act = 0, lk_own = 0;
  logic [1:0]  r;

  task automatic model_step();
    cyc++;
    if (mdl_on) begin
      if (t_act && cyc == t_s + 1) begin
        e_eadr = t_addr;
        if (t_we) e_sout = t_wdata;
      end
      if (t_act && !t_we && cyc == t_s + RC) t_rd = bus.spy_in;
      if (t_act && !t_we && cyc == t_ack) begin
        if (t_own) e_rd1 = t_rd; else e_rd0 = t_rd;
      end
      in_tx = t_act && cyc >= t_s && cyc <= t_ack;
      chk("m_grant",   bus.grant,   in_tx ? (t_own ? 2'b10 : 2'b01) : 2'b00);
      chk("m_busy",    bus.busy,    in_tx);
      chk("m_dbread",  bus.dbread,  t_act && !t_we && cyc >= t_s + 1 && cyc <= t_s + RC);
      chk("m_dbwrite", bus.dbwrite, t_act &&  t_we && cyc >= t_s + 1 && cyc <= t_s + WC);
      chk("m_ack0",    bus.ack0,    t_act && cyc == t_ack && !t_own);
      chk("m_ack1",    bus.ack1,    t_act && cyc == t_ack &&  t_own);
      chk("m_eadr",    bus.eadr,    e_eadr);
      chk("m_spy_out", bus.spy_out, e_sout);
      chk("m_rdata0",  bus.rdata0,  e_rd0);
      chk("m_rdata1",  bus.rdata1,  e_rd1);
    end
    if (reset) begin
      mdl_on = 1; t_act = 0; last = 1; lk_act = 0;
      e_eadr = '0; e_sout = '0; e_rd0 = '0; e_rd1 = '0;
    end else if (mdl_on) begin
      if (t_act && cyc == t_ack) begin
        last = t_own;
        if (t_own ? bus.lock1 : bus.lock0) begin
`ifdef SPY_ARB_LOCK_EN
          lk_act = 1; lk_own = t_own;
`endif
        end
        t_act = 0;
      end else if (!t_act) begin
        r = {bus.req1, bus.req0};
`ifdef SPY_ARB_LOCK_EN
        if (lk_act) begin
          if (lk_own ? bus.lock1 : bus.lock0) r = r & (lk_own ? 2'b10 : 2'b01);
          else lk_act = 0;
        end
`endif
        if (r != 2'b00) begin
          t_own   = (r == 2'b11) ? !last : r[1];
          t_we    = t_own ? bus.we1 : bus.we0;
          t_addr  = t_own ? bus.addr1 : bus.addr0;
          t_wdata = t_own ? bus.wdata1 : bus.wdata0;
          t_s     = cyc + 1;
          t_ack   = t_we ? t_s + 2 + WC : t_s + 1 + RC;
          t_act   = 1;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int who, output int n);
    who = -1;
    n   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (bus.ack0) begin who = 0; return; end
      if (bus.ack1) begin who = 1; return; end
    end
    total++;
    bad++;
    $display("FAIL ack_timeout: got none want ack within 40 cycles at t=%0t", $time);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_grant",   bus.grant,   2'b00);
    chk("rst_busy",    bus.busy,    1'b0);
    chk("rst_eadr",    bus.eadr,    5'h00);
    chk("rst_spy_out", bus.spy_out, 16'h0000);
    chk("rst_dbread",  bus.dbread,  1'b0);
    chk("rst_dbwrite", bus.dbwrite, 1'b0);
    chk("rst_ack0",    bus.ack0,    1'b0);
    chk("rst_ack1",    bus.ack1,    1'b0);
    chk("rst_rdata0",  bus.rdata0,  16'h0000);
    chk("rst_rdata1",  bus.rdata1,  16'h0000);
  endtask

  task automatic run_stim();
    int who, n;
    int seq[4];
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.lock0 = 0; bus.lock1 = 0; bus.spy_in = '0;
    do_reset();

    // Single read by requester 0.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5'h04; bus.spy_in = 16'hBEEF;
    tick(); chk("rd_c1_grant", bus.grant, 2'b01); chk("rd_c1_dbread", bus.dbread, 1'b0);
    tick(); chk("rd_c2_dbread", bus.dbread, 1'b1); chk("rd_c2_eadr", bus.eadr, 5'h04);
    tick(); chk("rd_c3_dbread", bus.dbread, 1'b1); chk("rd_c3_ack0", bus.ack0, 1'b0);
    tick(); chk("rd_c4_ack0", bus.ack0, 1'b1); chk("rd_c4_dbread", bus.dbread, 1'b0);
    chk("rd_c4_rdata0", bus.rdata0, 16'hBEEF); chk("rd_c4_rdata1", bus.rdata1, 16'h0000);
    bus.req0 = 0;
    tick(); chk("rd_c5_ack0", bus.ack0, 1'b0);

    // Single write by requester 1.
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5'h1A; bus.wdata1 = 16'h1234;
    tick();
    tick(); chk("wr_c2_dbwrite", bus.dbwrite, 1'b1); chk("wr_c2_eadr", bus.eadr, 5'h1A);
    chk("wr_c2_spy_out", bus.spy_out, 16'h1234);
    tick(); chk("wr_c3_dbwrite", bus.dbwrite, 1'b0); chk("wr_c3_ack1", bus.ack1, 1'b0);
    tick(); chk("wr_c4_ack1", bus.ack1, 1'b1); chk("wr_c4_rdata1", bus.rdata1, 16'h0000);
    chk("wr_c4_rdata0", bus.rdata0, 16'hBEEF);
    bus.req1 = 0;
    tick();

    // Simultaneous requests straight after reset: requester 0 first.
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5'h07; bus.spy_in = 16'hA5A5;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5'h03; bus.wdata1 = 16'h5A5A;
    wait_ack(who, n); chk("sim_first", who, 0); chk("sim_first_lat", n, 4);
    bus.req0 = 0;
    tick(); chk("sim_idle_grant", bus.grant, 2'b00);
    tick(); chk("sim_setup_grant", bus.grant, 2'b10);
    wait_ack(who, n); chk("sim_second", who, 1);
    bus.req1 = 0;
    tick();

    // Continuous contention: grants alternate 0,1,0,1.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'h11; bus.wdata0 = 16'hCAFE;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5'h12; bus.spy_in = 16'h1357;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, n);
      seq[k] = who;
      if (k == 3) begin bus.req0 = 0; bus.req1 = 0; end
    end
    for (int k = 0; k < 4; k++) chk("rr_order", seq[k], k % 2);
    tick(); chk("rr_rdata1", bus.rdata1, 16'h1357); chk("rr_spy_out", bus.spy_out, 16'hCAFE);

    // Reset during the READ strobe.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5'h09; bus.spy_in = 16'h2468;
    tick();
    tick(); chk("rr_mid_dbread", bus.dbread, 1'b1);
    reset = 1;
    tick(); chk("rst_mid_dbread", bus.dbread, 1'b0); chk("rst_mid_ack0", bus.ack0, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0); chk("rst_mid_grant", bus.grant, 2'b00);
    reset = 0; bus.req0 = 0;
    tick();
    bus.req0 = 1; bus.req1 = 1; bus.we1 = 0;
    wait_ack(who, n); chk("rst_mid_lastgrant", who, 0);
    bus.req0 = 0; bus.req1 = 0;
    tick();

    // Request dropped before ack still completes.
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5'h1F; bus.wdata1 = 16'hFFFF;
    tick(); bus.req1 = 0;
    wait_ack(who, n); chk("drop_who", who, 1); chk("drop_lat", n, 3);
    chk("drop_eadr", bus.eadr, 5'h1F); chk("drop_spy_out", bus.spy_out, 16'hFFFF);
    tick();

`ifdef SPY_ARB_LOCK_EN
    // Locked requester 0 keeps the bus until it releases the lock.
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.lock0 = 1; bus.addr0 = 5'h02; bus.spy_in = 16'h0F0F;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5'h05; bus.wdata1 = 16'h7777;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, n);
      seq[k] = who;
      if (k == 2) bus.lock0 = 0;
      if (k == 3) begin bus.req0 = 0; bus.req1 = 0; end
    end
    chk("lock_0", seq[0], 0); chk("lock_1", seq[1], 0);
    chk("lock_2", seq[2], 0); chk("lock_3", seq[3], 1);
    tick();
`endif
    tick();
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          model_step();
        end
      end
      begin
        run_stim();
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
